// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - initiator for the ALU select/A/B -> Z interface
//
// Takes one request (op, A, B) over a valid/ready handshake. It drives the ALU
// select lines for exactly one clock, then captures the ALU's registered 64-bit
// Z result. The result is returned over a valid/ready response port. Illegal
// ops and divide-by-zero are answered with an error response and are never
// issued to the ALU.
//
// Ports
//   clk          in   1      clock, all state changes on posedge
//   clear        in   1      asynchronous active-high reset
//   req_valid    in   1      request present
//   req_ready    out  1      sequencer can accept (IDLE only, low while clear)
//   req_op       in   4      ALU select code
//   req_a        in   32     operand A
//   req_b        in   32     operand B
//   alu_select   out  4      ALU select, 4'b0000 (hold) outside ISSUE
//   alu_a        out  32     ALU operand A (registered copy of req_a)
//   alu_b        out  32     ALU operand B (registered copy of req_b)
//   alu_z        in   64     ALU result {HI, LO}
//   rsp_valid    out  1      response present
//   rsp_ready    in   1      consumer takes response
//   rsp_lo       out  32     captured Z[31:0]
//   rsp_hi       out  32     captured Z[63:32]
//   rsp_hi_we    out  1      consumer writes HI too (MUL/DIV)
//   rsp_err      out  1      illegal op or divide-by-zero
//   op_count     out  CNT_W  completed responses, saturating

module alu_op_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic [3:0]       alu_select,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  input  logic [63:0]      alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_lo,
  output logic [31:0]      rsp_hi,
  output logic             rsp_hi_we,
  output logic             rsp_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [3:0] OP_HOLD = 4'b0000;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_DIV  = 4'b0101;

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi;
  logic             r_hi_we;
  logic             r_err;
  logic [CNT_W-1:0] r_count;

  logic w_op_legal;
  logic w_div_zero;
  logic w_req_err;
  logic w_count_full;

  // Codes with no ALU function behind them; 0000 is the ALU hold code.
  always_comb begin
    w_op_legal = 1'b1;
    case (req_op)
      4'b0000, 4'b0100, 4'b1011: w_op_legal = 1'b0;
      default:                   w_op_legal = 1'b1;
    endcase
  end

  assign w_div_zero   = (req_op == OP_DIV) && (req_b == 32'd0);
  assign w_req_err    = !w_op_legal || w_div_zero;
  assign w_count_full = &r_count;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_op    <= OP_HOLD;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_lo    <= 32'd0;
      r_hi    <= 32'd0;
      r_hi_we <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op <= req_op;
            r_a  <= req_a;
            r_b  <= req_b;
            if (w_req_err) begin
              // Error responses skip the ALU entirely and carry a zero result.
              r_lo    <= 32'd0;
              r_hi    <= 32'd0;
              r_hi_we <= 1'b0;
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // ALU registers Z on this edge; its output is valid during WAIT.
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_lo    <= alu_z[31:0];
          r_hi    <= alu_z[63:32];
          r_hi_we <= (r_op == OP_MUL) || (r_op == OP_DIV);
          r_err   <= 1'b0;
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            if (!w_count_full) begin
              r_count <= r_count + CNT_W'(1);
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by clear so the request port is closed for the whole reset pulse.
  assign req_ready  = (r_state == S_IDLE) && !clear;
  assign alu_select = (r_state == S_ISSUE) ? r_op : OP_HOLD;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_lo     = r_lo;
  assign rsp_hi     = r_hi;
  assign rsp_hi_we  = r_hi_we;
  assign rsp_err    = r_err;
  assign op_count   = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear;
  logic        req_valid;
  logic        rsp_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [63:0] alu_z = 64'd0;

  logic        req_ready;
  logic [3:0]  alu_select;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        rsp_valid;
  logic [31:0] rsp_lo;
  logic [31:0] rsp_hi;
  logic        rsp_hi_we;
  logic        rsp_err;
  logic [15:0] op_count;

  logic        c2_req_ready;
  logic [3:0]  c2_alu_select;
  logic [31:0] c2_alu_a;
  logic [31:0] c2_alu_b;
  logic        c2_rsp_valid;
  logic [31:0] c2_rsp_lo;
  logic [31:0] c2_rsp_hi;
  logic        c2_rsp_hi_we;
  logic        c2_rsp_err;
  logic [1:0]  c2_op_count;

  alu_op_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_select(alu_select), .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(rsp_lo), .rsp_hi(rsp_hi),
    .rsp_hi_we(rsp_hi_we), .rsp_err(rsp_err), .op_count(op_count)
  );

  alu_op_sequencer #(.CNT_W(2)) dut_c2 (
    .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(c2_req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_select(c2_alu_select), .alu_a(c2_alu_a), .alu_b(c2_alu_b), .alu_z(alu_z),
    .rsp_valid(c2_rsp_valid), .rsp_ready(rsp_ready), .rsp_lo(c2_rsp_lo), .rsp_hi(c2_rsp_hi),
    .rsp_hi_we(c2_rsp_hi_we), .rsp_err(c2_rsp_err), .op_count(c2_op_count)
  );

  // Registered ALU: Z updates only on a non-hold select; HI is kept for
  // ops that produce only a 32-bit result.
  function automatic logic [63:0] alu_f(input logic [3:0] s, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi);
    logic [63:0] p;
    logic [5:0]  sh;
    sh = {1'b0, b[4:0]};
    case (s)
      4'b0001: return {hi, a + b};
      4'b0010: return {hi, a - b};
      4'b0011: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        return p;
      end
      4'b0101: return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      4'b0110: return {hi, a & b};
      4'b0111: return {hi, a | b};
      4'b1000: return {hi, -a};
      4'b1001: return {hi, a};
      4'b1010: return {hi, ~a};
      4'b1100: return {hi, a << sh};
      4'b1101: return {hi, a >> sh};
      4'b1110: return {hi, (a << sh) | (a >> (6'd32 - sh))};
      4'b1111: return {hi, (a >> sh) | (a << (6'd32 - sh))};
      default: return {hi, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_select != 4'b0000) alu_z <= alu_f(alu_select, alu_a, alu_b, alu_z[63:32]);
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        we;
    logic        err;
  } vec_t;

  vec_t tbl[15];

  // Presents a request, waits for rsp_valid; lat = edges after accept,
  // issues = cycles with a non-hold select.
  task automatic run_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int issues, output logic [3:0] sel_seen);
    @(negedge clk);
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    lat = 0; issues = 0; sel_seen = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (alu_select != 4'b0000) begin
        issues++;
        sel_seen = alu_select;
      end
      if (rsp_valid) break;
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  int          lat;
  int          issues;
  logic [3:0]  sel;
  int          exp_cnt;
  int          exp_c2;

  initial begin
    tbl[0]  = '{4'b0001, 32'd5,         32'd7,      32'd12,        32'd0,         1'b0, 1'b0};
    tbl[1]  = '{4'b0011, 32'hFFFFFFFD,  32'd100000, 32'hFFFB6C20,  32'hFFFFFFFF,  1'b1, 1'b0};
    tbl[2]  = '{4'b0110, 32'h0000F0F0,  32'h0000FF00, 32'h0000F000, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[3]  = '{4'b0101, 32'd7,         32'd0,      32'd0,         32'd0,         1'b0, 1'b1};
    tbl[4]  = '{4'b1011, 32'd3,         32'd4,      32'd0,         32'd0,         1'b0, 1'b1};
    tbl[5]  = '{4'b0101, 32'hFFFFFFF9,  32'd2,      32'hFFFFFFFD,  32'hFFFFFFFF,  1'b1, 1'b0};
    tbl[6]  = '{4'b0111, 32'h0000000F,  32'h000000F0, 32'h000000FF, 32'hFFFFFFFF, 1'b0, 1'b0};
    tbl[7]  = '{4'b0010, 32'd10,        32'd3,      32'd7,         32'hFFFFFFFF,  1'b0, 1'b0};
    tbl[8]  = '{4'b1100, 32'd1,         32'd4,      32'd16,        32'hFFFFFFFF,  1'b0, 1'b0};
    tbl[9]  = '{4'b1010, 32'd0,         32'd0,      32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 1'b0};
    tbl[10] = '{4'b0000, 32'd1,         32'd1,      32'd0,         32'd0,         1'b0, 1'b1};
    tbl[11] = '{4'b0100, 32'd1,         32'd1,      32'd0,         32'd0,         1'b0, 1'b1};
    tbl[12] = '{4'b0011, 32'd65536,     32'd65536,  32'd0,         32'd1,         1'b1, 1'b0};
    tbl[13] = '{4'b1000, 32'd5,         32'd0,      32'hFFFFFFFB,  32'd1,         1'b0, 1'b0};
    tbl[14] = '{4'b1111, 32'd1,         32'd1,      32'h80000000,  32'd1,         1'b0, 1'b0};

    clear = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_select", 64'(alu_select), 64'd0);
    chk("rst_rsp_lo", 64'(rsp_lo), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    repeat (2) @(negedge clk);
    clear = 1'b0;

    exp_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      run_req(tbl[i].op, tbl[i].a, tbl[i].b, lat, issues, sel);
      chk($sformatf("v%0d_latency", i), 64'(lat), tbl[i].err ? 64'd0 : 64'd2);
      chk($sformatf("v%0d_issue_cycles", i), 64'(issues), tbl[i].err ? 64'd0 : 64'd1);
      chk($sformatf("v%0d_select", i), 64'(sel), tbl[i].err ? 64'd0 : 64'(tbl[i].op));
      chk($sformatf("v%0d_rsp_lo", i), 64'(rsp_lo), 64'(tbl[i].lo));
      chk($sformatf("v%0d_rsp_hi", i), 64'(rsp_hi), 64'(tbl[i].hi));
      chk($sformatf("v%0d_rsp_hi_we", i), 64'(rsp_hi_we), 64'(tbl[i].we));
      chk($sformatf("v%0d_rsp_err", i), 64'(rsp_err), 64'(tbl[i].err));
      chk($sformatf("v%0d_req_ready_busy", i), 64'(req_ready), 64'd0);
      if (!tbl[i].err) begin
        chk($sformatf("v%0d_alu_a", i), 64'(alu_a), 64'(tbl[i].a));
        chk($sformatf("v%0d_alu_b", i), 64'(alu_b), 64'(tbl[i].b));
      end
      @(posedge clk);
      @(negedge clk);
      exp_cnt++;
      chk($sformatf("v%0d_rsp_valid_drop", i), 64'(rsp_valid), 64'd0);
      chk($sformatf("v%0d_op_count", i), 64'(op_count), 64'(exp_cnt));
    end

    // Response held under back-pressure.
    rsp_ready = 1'b0;
    run_req(4'b0010, 32'd10, 32'd3, lat, issues, sel);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_lo", 64'(rsp_lo), 64'd7);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_cnt++;
    chk("hold_release_valid", 64'(rsp_valid), 64'd0);
    chk("hold_op_count", 64'(op_count), 64'(exp_cnt));

    // Asynchronous clear while in WAIT.
    @(negedge clk);
    req_op = 4'b0001; req_a = 32'd9; req_b = 32'd9; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("clr_issue_select", 64'(alu_select), 64'h1);
    @(posedge clk);
    #2 clear = 1'b1;
    #1;
    chk("clr_req_ready", 64'(req_ready), 64'd0);
    chk("clr_alu_select", 64'(alu_select), 64'd0);
    chk("clr_alu_a", 64'(alu_a), 64'd0);
    chk("clr_alu_b", 64'(alu_b), 64'd0);
    chk("clr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("clr_rsp_lo_hi", {rsp_hi, rsp_lo}, 64'd0);
    chk("clr_rsp_flags", 64'({rsp_hi_we, rsp_err}), 64'd0);
    chk("clr_op_count", 64'(op_count), 64'd0);
    chk("clr_c2_op_count", 64'(c2_op_count), 64'd0);
    @(negedge clk);
    clear = 1'b0;

    // Five back-to-back ops: the 2-bit counter saturates at 3.
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      run_req(4'b0001, 32'd1, 32'(i + 1), lat, issues, sel);
      chk($sformatf("post_clr%0d_rsp_lo", i), 64'(rsp_lo), 64'(i + 2));
      chk($sformatf("post_clr%0d_latency", i), 64'(lat), 64'd2);
      @(posedge clk);
      @(negedge clk);
      exp_cnt++;
      exp_c2 = (exp_cnt > 3) ? 3 : exp_cnt;
      chk($sformatf("sat%0d_op_count16", i), 64'(op_count), 64'(exp_cnt));
      chk($sformatf("sat%0d_op_count2", i), 64'(c2_op_count), 64'(exp_c2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
